kbd_key_tracker: RTL and testbench

- Parametrised multi-key state tracker with typematic auto-repeat; successor to the fixed four-decoder keypad arrangement.
- Consumes the make/break strobes and scan code from the PS/2 front end (keyboard module) and tracks NUM_KEYS configurable keys.
- Per key, produces held level, one-cycle press and release pulses, and an internally timed repeat pulse for the most recently pressed key.
- Feeds game control logic (flippers, plunger, start) directly.

---
 rtl/kbd_pkg.sv | 25 ++
 rtl/kbd_repeat_timer.sv | 87 ++++++++
 rtl/kbd_key_tracker.sv | 129 ++++++++++++
 tb/tb_kbd_key_tracker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared definitions for the keyboard key tracker slice.
//   KEY_CODE_W  : width of a PS/2 scan code as delivered by the front end
//   KP0..KP6    : keypad scan codes used by the default key map
//   rep_state_t : states of the typematic repeat timer
//   max_int     : elaboration-time helper for sizing counters
package kbd_pkg;

  localparam int KEY_CODE_W = 9;

  localparam logic [KEY_CODE_W-1:0] KP0 = 9'h070;
  localparam logic [KEY_CODE_W-1:0] KP4 = 9'h06B;
  localparam logic [KEY_CODE_W-1:0] KP5 = 9'h073;
  localparam logic [KEY_CODE_W-1:0] KP6 = 9'h074;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_DELAY  = 2'd1,
    R_REPEAT = 2'd2
  } rep_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/kbd_repeat_timer.sv
// kbd_repeat_timer: typematic delay/period timer for a single target key.
//   clk, resetN : clock and asynchronous active-low reset
//   start       : new press of some key; (re)arm with a fresh delay count
//   stop        : release of the current target key; return to idle
//   clear       : synchronous clear of the timer (highest priority)
//   tick        : combinational "repeat now" decision for the coming edge;
//                 the owner registers it together with the target index
module kbd_repeat_timer
  import kbd_pkg::*;
#(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input  logic clk,
  input  logic resetN,
  input  logic start,
  input  logic stop,
  input  logic clear,
  output logic tick
);

  localparam int CNT_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Counts hold at most max-1, so the truncated reloads never overflow.
  localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LOAD = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  rep_state_t       state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             tick_s;

  // State and counter registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r <= R_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state, counter and tick decision; clear > start > stop > counting.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    tick_s       = 1'b0;
    if (clear) begin
      state_next_s = R_IDLE;
      cnt_next_s   = CNT_ZERO;
    end else if (start) begin
      state_next_s = R_DELAY;
      cnt_next_s   = DLY_LOAD;
    end else if (stop) begin
      // No tick in the release cycle, even if the count expired.
      state_next_s = R_IDLE;
      cnt_next_s   = CNT_ZERO;
    end else begin
      case (state_r)
        R_IDLE: begin
          state_next_s = R_IDLE;
          cnt_next_s   = cnt_r;
        end
        R_DELAY, R_REPEAT: begin
          if (cnt_r == CNT_ZERO) begin
            tick_s       = 1'b1;
            state_next_s = R_REPEAT;
            cnt_next_s   = PER_LOAD;
          end else begin
            state_next_s = state_r;
            cnt_next_s   = cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_next_s = R_IDLE;
          cnt_next_s   = CNT_ZERO;
        end
      endcase
    end
  end

  assign tick = tick_s;

endmodule

// File: rtl/kbd_key_tracker.sv
// kbd_key_tracker: multi-key held/press/release tracker with typematic repeat.
//   clk, resetN     : clock and asynchronous active-low reset
//   make, breakk    : one-cycle press / release strobes from the PS/2 front end
//   key_code        : scan code, meaningful only while a strobe is high
//   clear           : synchronous clear of all key state (no release pulses)
//   keyIsPressed    : held level per tracked key
//   keyPressPulse   : one-cycle pulse on a new press
//   keyReleasePulse : one-cycle pulse on release of a held key
//   keyRepeatPulse  : one-cycle typematic pulse for the most recent new press
//   anyKeyPressed   : OR of keyIsPressed, aligned with it
//   lastKey         : index of the most recently newly pressed key
// Key i answers to KEY_VALUES[i*KEY_CODE_W +: KEY_CODE_W]; duplicate codes all act.
module kbd_key_tracker
  import kbd_pkg::*;
#(
  parameter int                           NUM_KEYS      = 4,
  parameter logic [NUM_KEYS*KEY_CODE_W-1:0] KEY_VALUES  = {KP4, KP6, KP5, KP0},
  parameter int                           REPEAT_DELAY  = 25_000_000,
  parameter int                           REPEAT_PERIOD = 2_500_000,
  localparam int                          LK_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  make,
  input  logic                  breakk,
  input  logic [KEY_CODE_W-1:0] key_code,
  input  logic                  clear,
  output logic [NUM_KEYS-1:0]   keyIsPressed,
  output logic [NUM_KEYS-1:0]   keyPressPulse,
  output logic [NUM_KEYS-1:0]   keyReleasePulse,
  output logic [NUM_KEYS-1:0]   keyRepeatPulse,
  output logic                  anyKeyPressed,
  output logic [LK_W-1:0]       lastKey
);

  logic [NUM_KEYS-1:0] level_r, press_r, release_r, repeat_r;
  logic                any_r;
  logic [LK_W-1:0]     last_r, rkey_r;

  logic [NUM_KEYS-1:0] match_s, press_s, release_s;
  logic [NUM_KEYS-1:0] level_next_s, repeat_next_s;
  logic [LK_W-1:0]     last_next_s, rkey_next_s;
  logic                make_eff_s, break_eff_s;
  logic                start_s, stop_s, tick_s;

  // A simultaneous make+breakk is a release; clear swallows both strobes.
  assign make_eff_s  = make & ~breakk & ~clear;
  assign break_eff_s = breakk & ~clear;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    assign match_s[g]   = (key_code == KEY_VALUES[g*KEY_CODE_W +: KEY_CODE_W]);
    // Resent makes of a held key are the keyboard's own typematic; ignore them.
    assign press_s[g]   = make_eff_s & match_s[g] & ~level_r[g];
    assign release_s[g] = break_eff_s & match_s[g] & level_r[g];
  end

  assign start_s = |press_s;
  assign stop_s  = release_s[rkey_r];

  kbd_repeat_timer #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_timer (
    .clk   (clk),
    .resetN(resetN),
    .start (start_s),
    .stop  (stop_s),
    .clear (clear),
    .tick  (tick_s)
  );

  // Next levels, last/repeat target selection and the one-hot repeat vector.
  always_comb begin
    level_next_s  = '0;
    last_next_s   = last_r;
    rkey_next_s   = rkey_r;
    repeat_next_s = '0;
    if (clear) begin
      level_next_s = '0;
    end else begin
      level_next_s = (level_r | press_s) & ~release_s;
    end
    // Highest matching index wins when several entries share one code.
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (press_s[i]) begin
        last_next_s = LK_W'(i);
        rkey_next_s = LK_W'(i);
      end else begin
        last_next_s = last_next_s;
        rkey_next_s = rkey_next_s;
      end
    end
    // tick is never raised in a start cycle, so rkey_r is the live target.
    if (tick_s) begin
      repeat_next_s[rkey_r] = 1'b1;
    end else begin
      repeat_next_s = '0;
    end
  end

  // Output and tracking registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      level_r   <= '0;
      press_r   <= '0;
      release_r <= '0;
      repeat_r  <= '0;
      any_r     <= 1'b0;
      last_r    <= '0;
      rkey_r    <= '0;
    end else begin
      level_r   <= level_next_s;
      press_r   <= press_s;
      release_r <= release_s;
      repeat_r  <= repeat_next_s;
      any_r     <= |level_next_s;
      last_r    <= last_next_s;
      rkey_r    <= rkey_next_s;
    end
  end

  assign keyIsPressed    = level_r;
  assign keyPressPulse   = press_r;
  assign keyReleasePulse = release_r;
  assign keyRepeatPulse  = repeat_r;
  assign anyKeyPressed   = any_r;
  assign lastKey         = last_r;

endmodule

// File: tb/tb_kbd_key_tracker.sv
// Self-checking bench for kbd_key_tracker: directed table, corner sequences,
// and random traffic against a cycle-count based reference model.
module tb_kbd_key_tracker;
  import kbd_pkg::*;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       make = 1'b0, breakk = 1'b0, clear = 1'b0;
  logic [8:0] key_code = 9'h000;

  logic [3:0] lvl, prs, rel, rep;
  logic       any;
  logic [1:0] last;
  logic [3:0] lvl1, prs1, rel1, rep1;
  logic       any1;
  logic [1:0] last1;

  always #5 clk = ~clk;

  kbd_key_tracker #(.NUM_KEYS(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)) dut (
    .clk(clk), .resetN(resetN), .make(make), .breakk(breakk), .key_code(key_code),
    .clear(clear), .keyIsPressed(lvl), .keyPressPulse(prs), .keyReleasePulse(rel),
    .keyRepeatPulse(rep), .anyKeyPressed(any), .lastKey(last));

  kbd_key_tracker #(.NUM_KEYS(4), .REPEAT_DELAY(1), .REPEAT_PERIOD(1)) dut1 (
    .clk(clk), .resetN(resetN), .make(make), .breakk(breakk), .key_code(key_code),
    .clear(clear), .keyIsPressed(lvl1), .keyPressPulse(prs1), .keyReleasePulse(rel1),
    .keyRepeatPulse(rep1), .anyKeyPressed(any1), .lastKey(last1));

  // Reference model: which keys are held, the repeat target, and the cycle
  // of its press; repeat pulses are derived from elapsed cycles.
  logic [8:0] codes [4] = '{9'h070, 9'h073, 9'h074, 9'h06B};
  logic [3:0] m_level, m_press, m_rel;
  int         m_last, m_tgt, m_t0, cyc;
  bit         m_active;
  int         checks = 0, errors = 0;

  typedef struct {
    bit mk; bit bk; logic [8:0] code; bit clr;
    logic [3:0] lvl; logic [3:0] prs; logic [3:0] rel; int last;
  } vec_t;
  vec_t tbl [$];

  task automatic model_reset();
    m_level = 4'b0; m_press = 4'b0; m_rel = 4'b0;
    m_last = 0; m_tgt = 0; m_t0 = 0; m_active = 0;
  endtask

  task automatic model_step(input bit mk, input bit bk, input logic [8:0] code, input bit clr);
    m_press = 4'b0; m_rel = 4'b0;
    if (clr) begin
      m_level = 4'b0; m_active = 0;
    end else if (bk) begin
      for (int i = 0; i < 4; i++)
        if (code == codes[i] && m_level[i]) begin
          m_rel[i] = 1'b1; m_level[i] = 1'b0;
          if (i == m_tgt) m_active = 0;
        end
    end else if (mk) begin
      for (int i = 0; i < 4; i++)
        if (code == codes[i] && !m_level[i]) begin
          m_press[i] = 1'b1; m_level[i] = 1'b1;
          m_last = i; m_tgt = i; m_active = 1; m_t0 = cyc;
        end
    end
  endtask

  function automatic logic [3:0] exp_rep(input int d, input int p);
    int el;
    el = cyc - m_t0;
    if (m_active && el >= d && ((el - d) % p) == 0) return 4'b0001 << m_tgt;
    return 4'b0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    chk("level", {28'b0, lvl}, {28'b0, m_level});
    chk("press", {28'b0, prs}, {28'b0, m_press});
    chk("release", {28'b0, rel}, {28'b0, m_rel});
    chk("any", {31'b0, any}, {31'b0, |m_level});
    chk("lastKey", {30'b0, last}, m_last);
    chk("repeat", {28'b0, rep}, {28'b0, exp_rep(10, 4)});
    chk("repeat_d1p1", {28'b0, rep1}, {28'b0, exp_rep(1, 1)});
  endtask

  task automatic step(input bit mk, input bit bk, input logic [8:0] code, input bit clr);
    make = mk; breakk = bk; key_code = code; clear = clr;
    @(posedge clk);
    cyc++;
    model_step(mk, bk, code, clr);
    #1;
    check_all();
    make = 1'b0; breakk = 1'b0; clear = 1'b0; key_code = 9'h000;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 9'h000, 0);
  endtask

  task automatic add(input bit mk, input bit bk, input logic [8:0] code, input bit clr,
                     input logic [3:0] l, input logic [3:0] p, input logic [3:0] r, input int lk);
    vec_t v;
    v.mk = mk; v.bk = bk; v.code = code; v.clr = clr;
    v.lvl = l; v.prs = p; v.rel = r; v.last = lk;
    tbl.push_back(v);
  endtask

  initial begin
    int cnt, cnt1;
    logic [8:0] pool [5];
    cyc = 0;
    model_reset();
    pool = '{9'h070, 9'h073, 9'h074, 9'h06B, 9'h01C};

    // Table: starts from the reset state (lastKey 0, nothing held).
    add(1, 0, 9'h073, 0, 4'b0010, 4'b0010, 4'b0000, 1);
    add(0, 0, 9'h000, 0, 4'b0010, 4'b0000, 4'b0000, 1);
    add(1, 0, 9'h074, 0, 4'b0110, 4'b0100, 4'b0000, 2);
    add(1, 0, 9'h073, 0, 4'b0110, 4'b0000, 4'b0000, 2);
    add(1, 1, 9'h074, 0, 4'b0010, 4'b0000, 4'b0100, 2);
    add(0, 1, 9'h074, 0, 4'b0010, 4'b0000, 4'b0000, 2);
    add(1, 0, 9'h01C, 0, 4'b0010, 4'b0000, 4'b0000, 2);
    add(0, 1, 9'h073, 0, 4'b0000, 4'b0000, 4'b0010, 2);
    add(1, 0, 9'h06B, 0, 4'b1000, 4'b1000, 4'b0000, 3);
    add(1, 0, 9'h070, 1, 4'b0000, 4'b0000, 4'b0000, 3);
    add(1, 0, 9'h070, 0, 4'b0001, 4'b0001, 4'b0000, 0);
    add(0, 1, 9'h070, 0, 4'b0000, 4'b0000, 4'b0001, 0);

    // Reset state.
    @(posedge clk); #1;
    check_all();
    @(negedge clk); resetN = 1'b1;

    // Asynchronous reset while a repeat is running.
    step(1, 0, 9'h070, 0);
    idle(12);
    #2 resetN = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk); resetN = 1'b1;

    // Directed table.
    foreach (tbl[t]) begin
      step(tbl[t].mk, tbl[t].bk, tbl[t].code, tbl[t].clr);
      chk("tbl_level", {28'b0, lvl}, {28'b0, tbl[t].lvl});
      chk("tbl_press", {28'b0, prs}, {28'b0, tbl[t].prs});
      chk("tbl_release", {28'b0, rel}, {28'b0, tbl[t].rel});
      chk("tbl_lastKey", {30'b0, last}, tbl[t].last);
    end

    // Held key with device resends every 3 cycles: repeat cadence undisturbed.
    step(1, 0, 9'h070, 0);
    cnt = 0; cnt1 = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k % 3 == 0) step(1, 0, 9'h070, 0);
      else step(0, 0, 9'h000, 0);
      cnt  += rep[0] ? 1 : 0;
      cnt1 += rep1[0] ? 1 : 0;
      chk("resend_no_press", {28'b0, prs}, 32'd0);
    end
    chk("resend_rep_count", cnt, 32'd6);
    chk("resend_rep_count_d1p1", cnt1, 32'd30);
    step(0, 1, 9'h070, 0);

    // Retarget to a later press, release of non-target, release of target.
    step(1, 0, 9'h070, 0);
    idle(5);
    step(1, 0, 9'h06B, 0);
    idle(12);
    step(0, 1, 9'h070, 0);
    idle(6);
    step(0, 1, 9'h06B, 0);
    chk("retarget_rel", {28'b0, rel}, 32'h8);
    chk("retarget_lvl", {28'b0, lvl}, 32'h0);
    idle(6);

    // Clear while two keys are held and repeating.
    step(1, 0, 9'h070, 0);
    step(1, 0, 9'h074, 0);
    idle(15);
    step(0, 0, 9'h000, 1);
    chk("clear_lvl", {28'b0, lvl}, 32'h0);
    chk("clear_any", {31'b0, any}, 32'h0);
    idle(12);

    // Fast-repeat instance: pulse every cycle from one after the press.
    step(1, 0, 9'h074, 0);
    idle(5);
    chk("fast_rep", {28'b0, rep1}, 32'h4);
    step(0, 1, 9'h074, 0);
    idle(2);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      bit mk, bk, cl;
      mk = ($urandom_range(0, 99) < 25);
      bk = ($urandom_range(0, 99) < 15);
      cl = ($urandom_range(0, 199) == 0);
      step(mk, bk, pool[$urandom_range(0, 4)], cl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
